sd_sector_arbiter: RTL

Shares the single SD-card sector reader between two requesters: the boot ROM image loader (port 0) and the settings/audit loader (port 1). It arbitrates round-robin, issues the sector start to the reader and routes the 512-byte stream (`data_sd_card`, `byte_count`) to the granted requester's buffer. It also detects reader errors and stalled transfers. It sits in the `clk_27` domain between the SD_CARD reader and the RAM loaders.

---
 rtl/sd_sector_arbiter_if.sv | 48 ++++
 rtl/sd_sector_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_sector_arbiter_if
// Bundles every handshake/bus signal of sd_sector_arbiter: the two requester
// ports (req/lba/gnt/done/err/out_we), the SD sector-reader side
// (sd_ready/sd_start/sd_lba/sd_byte_valid/sd_data/sd_error) and the shared
// byte write bus (out_data/out_addr) plus busy.
//   slave  : the arbiter's view (serves the requesters, drives the reader).
//   master : the environment's view (requesters + reader model).
// ---------------------------------------------------------------------------
interface sd_sector_arbiter_if;
    logic        req0;
    logic        req1;
    logic [31:0] lba0;
    logic [31:0] lba1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic        sd_ready;
    logic        sd_start;
    logic [31:0] sd_lba;
    logic        sd_byte_valid;
    logic [7:0]  sd_data;
    logic        sd_error;
    logic [7:0]  out_data;
    logic [8:0]  out_addr;
    logic        out_we0;
    logic        out_we1;
    logic        busy;

    modport slave (
        input  req0, req1, lba0, lba1,
        input  sd_ready, sd_byte_valid, sd_data, sd_error,
        output gnt0, gnt1, done0, done1, err0, err1,
        output sd_start, sd_lba,
        output out_data, out_addr, out_we0, out_we1, busy
    );

    modport master (
        output req0, req1, lba0, lba1,
        output sd_ready, sd_byte_valid, sd_data, sd_error,
        input  gnt0, gnt1, done0, done1, err0, err1,
        input  sd_start, sd_lba,
        input  out_data, out_addr, out_we0, out_we1, busy
    );
endinterface

// File: rtl/sd_sector_arbiter.sv
// ---------------------------------------------------------------------------
// sd_sector_arbiter
// Shares one SD-card sector reader between the boot ROM loader (port 0) and
// the settings/audit loader (port 1). Round-robin arbitration, issues the
// sector start, routes the 512-byte stream to the granted port's buffer and
// aborts on reader error or on a stalled transfer.
//
// Ports:
//   clk_27 : 27 MHz system clock
//   reset  : asynchronous, active-high
//   bus    : sd_sector_arbiter_if.slave
//            req0/req1, lba0/lba1   requester level requests and sector addresses
//            gnt0/gnt1              one-hot grant, high for the whole transfer
//            done0/done1, err0/err1 one-cycle completion / abort pulses
//            sd_ready, sd_start, sd_lba, sd_byte_valid, sd_data, sd_error
//                                   sector reader handshake and byte stream
//            out_data, out_addr, out_we0/out_we1
//                                   registered byte write to the granted port
//            busy                   high in every state except IDLE
//
// Every output comes straight from a flop; nothing combinational reaches an
// output port.
// ---------------------------------------------------------------------------
module sd_sector_arbiter #(
    parameter int TIMEOUT_CYCLES = 13_500_000,
    parameter int SECTOR_BYTES   = 512
) (
    input  logic               clk_27,
    input  logic               reset,
    sd_sector_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DATA,
        S_XFER,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [9:0]  LAST_BYTE = 10'(SECTOR_BYTES - 1);
    localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic        sd_start_q, sd_start_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [8:0]  out_addr_q, out_addr_d;
    logic        out_we0_q, out_we0_d;
    logic        out_we1_q, out_we1_d;
    logic        busy_q, busy_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [23:0] tmo_q, tmo_d;
    logic        pick1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        sd_start_d   = 1'b0;
        sd_lba_d     = sd_lba_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        out_we0_d    = 1'b0;
        out_we1_d    = 1'b0;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;

        // Port 1 wins when it is alone, or on a tie when port 0 was served last.
        pick1 = bus.req1 & (~bus.req0 | ~last_grant_q);

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt0_d       = ~pick1;
                    gnt1_d       = pick1;
                    last_grant_d = pick1;
                    sd_lba_d     = pick1 ? bus.lba1 : bus.lba0;
                    cnt_d        = '0;
                    tmo_d        = '0;
                    state_d      = S_START;
                end
            end

            // No timeout here: the reader may still be initialising.
            S_START: begin
                if (bus.sd_ready) begin
                    sd_start_d = 1'b1;
                    state_d    = S_WAIT_DATA;
                end
            end

            S_WAIT_DATA, S_XFER: begin
                if (bus.sd_byte_valid) begin
                    out_data_d = bus.sd_data;
                    out_addr_d = cnt_q[8:0];
                    out_we0_d  = gnt0_q;
                    out_we1_d  = gnt1_q;
                    cnt_d      = cnt_q + 10'd1;
                    tmo_d      = '0;
                    state_d    = S_XFER;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end

                // Error beats completion: a final byte arriving with sd_error
                // is still written, but the transfer ends in ERROR.
                if (bus.sd_error || (!bus.sd_byte_valid && tmo_q == TMO_LAST)) begin
                    err0_d  = gnt0_q;
                    err1_d  = gnt1_q;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    state_d = S_ERROR;
                end else if (bus.sd_byte_valid && cnt_q == LAST_BYTE) begin
                    state_d = S_DONE;
                end
            end

            // Two cycles: first raise done, then drop the grant and return to
            // IDLE, so the other port sees its grant no earlier than N+4.
            S_DONE: begin
                if (!done0_q && !done1_q) begin
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                end else begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            // Hold until the reader has recovered; no automatic retry.
            S_ERROR: begin
                if (bus.sd_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_27 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            sd_start_q   <= 1'b0;
            sd_lba_q     <= '0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            out_we0_q    <= 1'b0;
            out_we1_q    <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            sd_start_q   <= sd_start_d;
            sd_lba_q     <= sd_lba_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            out_we0_q    <= out_we0_d;
            out_we1_q    <= out_we1_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.err0     = err0_q;
    assign bus.err1     = err1_q;
    assign bus.sd_start = sd_start_q;
    assign bus.sd_lba   = sd_lba_q;
    assign bus.out_data = out_data_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_we0  = out_we0_q;
    assign bus.out_we1  = out_we1_q;
    assign bus.busy     = busy_q;

endmodule
